// File: rtl/vx_serial_divrem_unit.sv
// -----------------------------------------------------------------------------
// vx_serial_divrem_unit
//
// Multi-lane iterative integer divide/remainder engine for the M-extension
// path. One request is in flight at a time. Each active lane runs a restoring
// radix-2 divider on operand magnitudes, one quotient bit per cycle, and the
// RISC-V sign, divide-by-zero and signed-overflow rules are applied when the
// result is registered. Requests whose active lanes are all special cases
// (or that have no active lanes) skip the iteration and retire after one cycle.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   in_valid    request valid
//   in_ready    request accepted when in_valid & in_ready (high only in IDLE)
//   in_tag      opaque tag carried to the response
//   in_tmask    active-lane mask
//   in_signed   1 = signed operation, 0 = unsigned
//   in_rem      1 = return remainder, 0 = return quotient
//   in_numer    dividends, lane i at [i*WIDTH +: WIDTH]
//   in_denom    divisors, same packing
//   out_valid   response valid (DONE state)
//   out_ready   response consumed when out_valid & out_ready
//   out_tag     tag of the request being returned
//   out_tmask   lane mask of the request being returned
//   out_result  per-lane results, inactive lanes read 0
//   busy        high while a request is being computed or held
// -----------------------------------------------------------------------------
module vx_serial_divrem_unit #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int TAGW  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TAGW-1:0]        in_tag,
    input  logic [LANES-1:0]       in_tmask,
    input  logic                   in_signed,
    input  logic                   in_rem,
    input  logic [LANES*WIDTH-1:0] in_numer,
    input  logic [LANES*WIDTH-1:0] in_denom,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TAGW-1:0]        out_tag,
    output logic [LANES-1:0]       out_tmask,
    output logic [LANES*WIDTH-1:0] out_result,
    output logic                   busy
);

    localparam int               CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic   accept;

    // Control and response registers.
    logic [CW-1:0]          cnt_q;
    logic [TAGW-1:0]        tag_q;
    logic [LANES-1:0]       tmask_q;
    logic                   rem_sel_q;
    logic [LANES*WIDTH-1:0] result_q;

    // Per-lane datapath registers. quo_q starts as |numer| and shifts out its
    // dividend bits while quotient bits shift in from the bottom.
    logic [WIDTH-1:0] quo_q   [LANES];
    logic [WIDTH-1:0] prem_q  [LANES];
    logic [WIDTH-1:0] den_q   [LANES];
    logic [WIDTH-1:0] numer_q [LANES];
    logic [LANES-1:0] qneg_q, rneg_q, div0_q, ovf_q;

    // Request decode.
    logic [WIDTH-1:0] a_numer [LANES];
    logic [WIDTH-1:0] a_denom [LANES];
    logic [WIDTH-1:0] a_abs_n [LANES];
    logic [WIDTH-1:0] a_abs_d [LANES];
    logic [LANES-1:0] a_nneg, a_dneg, a_qneg, a_div0, a_ovf;
    logic             a_fast;
    logic [LANES*WIDTH-1:0] fast_result;

    // One restoring step.
    logic [WIDTH:0]   shifted [LANES];
    logic [WIDTH:0]   trial   [LANES];
    logic [WIDTH-1:0] s_quo   [LANES];
    logic [WIDTH-1:0] s_rem   [LANES];
    logic [LANES*WIDTH-1:0] calc_result;

    // Final per-lane value: special cases override the iterated magnitudes,
    // otherwise the magnitudes are re-signed (two's complement, mod 2^WIDTH).
    function automatic logic [WIDTH-1:0] lane_fixup(
        input logic             active,
        input logic             div0,
        input logic             ovf,
        input logic             qneg,
        input logic             rneg,
        input logic             sel_rem,
        input logic [WIDTH-1:0] raw_numer,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] rem
    );
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] res;
        if (div0) begin
            q = '1;
            r = raw_numer;
        end else if (ovf) begin
            q = MIN_VAL;
            r = '0;
        end else begin
            q = qneg ? -quo : quo;
            r = rneg ? -rem : rem;
        end
        res = sel_rem ? r : q;
        return active ? res : '0;
    endfunction

    // NOTE: every variable written in an always_comb gets a value on every
    // path (here by construction in the loop body) so no latch is inferred.
    always_comb begin
        a_fast      = 1'b1;
        fast_result = '0;
        for (int i = 0; i < LANES; i++) begin
            a_numer[i] = in_numer[i*WIDTH +: WIDTH];
            a_denom[i] = in_denom[i*WIDTH +: WIDTH];
            a_nneg[i]  = in_signed & a_numer[i][WIDTH-1];
            a_dneg[i]  = in_signed & a_denom[i][WIDTH-1];
            a_abs_n[i] = a_nneg[i] ? -a_numer[i] : a_numer[i];
            a_abs_d[i] = a_dneg[i] ? -a_denom[i] : a_denom[i];
            a_qneg[i]  = a_nneg[i] ^ a_dneg[i];
            a_div0[i]  = (a_denom[i] == '0);
            a_ovf[i]   = in_signed && (a_numer[i] == MIN_VAL) && (a_denom[i] == '1);
            if (in_tmask[i] && !(a_div0[i] || a_ovf[i])) begin
                a_fast = 1'b0;
            end
            // Only used when every active lane is special, so the iterated
            // magnitudes are never needed here.
            fast_result[i*WIDTH +: WIDTH] = lane_fixup(
                in_tmask[i], a_div0[i], a_ovf[i], a_qneg[i], a_nneg[i],
                in_rem, a_numer[i], '0, '0);
        end
    end

    // The shifted partial remainder is below 2*|denom|, so the trial
    // difference fits WIDTH+1 bits and its top bit is the borrow.
    always_comb begin
        calc_result = '0;
        for (int i = 0; i < LANES; i++) begin
            shifted[i] = {prem_q[i], quo_q[i][WIDTH-1]};
            trial[i]   = shifted[i] - {1'b0, den_q[i]};
            if (!trial[i][WIDTH]) begin
                s_rem[i] = trial[i][WIDTH-1:0];
                s_quo[i] = {quo_q[i][WIDTH-2:0], 1'b1};
            end else begin
                s_rem[i] = shifted[i][WIDTH-1:0];
                s_quo[i] = {quo_q[i][WIDTH-2:0], 1'b0};
            end
            calc_result[i*WIDTH +: WIDTH] = lane_fixup(
                tmask_q[i], div0_q[i], ovf_q[i], qneg_q[i], rneg_q[i],
                rem_sel_q, numer_q[i], s_quo[i], s_rem[i]);
        end
    end

    // Next state and handshake outputs, decoded from state only.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = a_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tag_q     <= '0;
            tmask_q   <= '0;
            rem_sel_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tag_q     <= in_tag;
                tmask_q   <= in_tmask;
                rem_sel_q <= in_rem;
                cnt_q     <= '0;
                if (a_fast) begin
                    result_q <= fast_result;
                end
            end else if (state_q == S_CALC) begin
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    result_q <= calc_result;
                end
            end
        end
    end

    // NOTE: the per-lane working registers have no reset; they are always
    // loaded on accept before being read, and reset only discards a request.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                quo_q[i]   <= a_abs_n[i];
                prem_q[i]  <= '0;
                den_q[i]   <= a_abs_d[i];
                numer_q[i] <= a_numer[i];
            end
            qneg_q <= a_qneg;
            rneg_q <= a_nneg;
            div0_q <= a_div0;
            ovf_q  <= a_ovf;
        end else if (state_q == S_CALC) begin
            for (int i = 0; i < LANES; i++) begin
                quo_q[i]  <= s_quo[i];
                prem_q[i] <= s_rem[i];
            end
        end
    end

    assign out_tag    = tag_q;
    assign out_tmask  = tmask_q;
    assign out_result = result_q;

endmodule

// File: doc/vx_serial_divrem_unit.md
Name: vx_serial_divrem_unit

Overview:
- Multi-lane iterative integer divide/remainder engine for the core's M-extension path; generalises the fixed divider: parametrised width, lane count and tag width.
- Per-lane thread mask, RISC-V divide-by-zero and overflow semantics, and a fast path that retires all-special or empty requests in one cycle.
- Sits between the execute dispatch and the commit stream arbiter.
- Single outstanding request with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width per lane (≥ 8, power of 2).
- LANES, 4, number of parallel lanes.
- TAGW, 8, opaque tag width carried request→response (uuid/wid/rd/etc. packed by caller).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_tag  in  TAGW  request tag.
- in_tmask  in  LANES  active-lane mask.
- in_signed  in  1  1 = signed div/rem, 0 = unsigned.
- in_rem  in  1  1 = return remainder, 0 = quotient.
- in_numer  in  LANES*WIDTH  dividends; lane i at [i*WIDTH +: WIDTH].
- in_denom  in  LANES*WIDTH  divisors, same packing.
- out_valid  out  1  response valid.
- out_ready  in  1  response consumed when out_valid & out_ready.
- out_tag  out  TAGW  tag of the request being returned.
- out_tmask  out  LANES  mask of the request being returned.
- out_result  out  LANES*WIDTH  per-lane results.
- busy  out  1  high in CALC or DONE.

Behaviour:
- States: IDLE, CALC, DONE. Reset (reset=0, async) → IDLE, cycle counter=0, out_valid=0, busy=0, out_tag/out_tmask/out_result=0. in_ready is 1 immediately after reset.
- in_ready = (state==IDLE), combinational from state only; never depends on in_valid.
- Accept in IDLE:
  - Latch tag, tmask, signed, rem.
  - Per lane, compute |numer| and |denom| when signed, and record the quotient and remainder negate flags: q_neg = sign(n) XOR sign(d); r_neg = sign(n).
  - Classify each lane as special:
    - div0: denom==0.
    - ovf: signed & numer==MIN & denom==all-ones.
  - Fast path: if every lane set in tmask is special, or tmask==0, go to DONE next cycle (latency 1).
  - Otherwise go to CALC with counter=0.
- CALC:
  - Restoring radix-2 step per lane per cycle: shift {rem,quo} left 1; trial subtract |denom|; set the quotient bit if non-negative.
  - The counter runs 0..WIDTH-1. Leave for DONE on the cycle counter==WIDTH-1. in_valid is ignored.
  - Total latency from the accept edge to out_valid=1 is WIDTH+1 cycles.
- Result fix-up happens on entry to DONE and is registered:
  - Normal lane: apply the negate flags.
  - div0: quotient = all-ones; remainder = numer (raw, un-negated).
  - ovf: quotient = MIN (numer); remainder = 0.
  - Unsigned div0 follows the same rule.
  - Inactive lanes (tmask bit 0) output 0.
  - Select by rem.
- DONE: out_valid=1 and outputs stable until out_valid & out_ready, then → IDLE. No back-to-back bypass: the earliest next accept is the cycle after the handshake.
- out_ready low is tolerated indefinitely in DONE. Changes on in_* are irrelevant outside IDLE.
- Reset asserted mid-CALC or in DONE: immediate return to IDLE, pending result discarded, out_valid drops asynchronously.
- Width rules:
  - Intermediate remainder WIDTH+1 bits.
  - MIN = 1 followed by WIDTH-1 zeros.
  - Negation is two's complement modulo 2^WIDTH.

Test Plan:
- WIDTH=32, LANES=4, unsigned, tmask=4'b1111, numer={100,7,0,0xFFFFFFFF}, denom={7,100,5,1}, quotient → {14,0,0,0xFFFFFFFF}. out_valid exactly 33 cycles after accept; in_ready low throughout.
- Signed rem, numer=-7 (0xFFFFFFF9), denom=2 → result 0xFFFFFFFF (-1). Signed div same operands → 0xFFFFFFFD (-3).
- All active lanes special: tmask=4'b0011, lane0 denom=0 numer=42, lane1 signed 0x80000000/0xFFFFFFFF.
  - Divide → out_valid 1 cycle after accept, lane0=0xFFFFFFFF, lane1=0x80000000, lanes2-3=0.
  - Rem → lane0=42, lane1=0.
- Mixed special + normal lane: lane0 denom=0, lane1 9/3 → full 33-cycle latency. lane0=0xFFFFFFFF, lane1=3.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid, out_tag=0xA5 and out_result stable, in_ready=0. On release, one handshake, then in_ready=1 next cycle.
- Drive reset=0 at CALC cycle 12 → out_valid=0, busy=0, in_ready=1 after release. A fresh request 50/5 returns 10 with the new tag.
